// File: rtl/jk_cmd_if.sv
// Command handshake between the request source and the JK command sequencer.
interface jk_cmd_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues set/clear/toggle requests and turns each into a spaced, one-hot J or K
// pulse; toggles are resolved against the fed-back Q so J and K never coincide.
module jk_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int GAP            = 2,
  parameter bit SKIP_REDUNDANT = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  jk_cmd_if.slave                cmd,
  input  logic                   Q_fb,
  output logic                   J,
  output logic                   K,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);
  localparam int  AW      = $clog2(DEPTH);
  localparam int  CW      = AW + 1;
  localparam bit  HAS_GAP = (GAP > 0);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      gap_cnt_reg, gap_cnt_next;
  logic            j_reg, j_next;
  logic            k_reg, k_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [1:0]      fifo_mem [DEPTH];
  logic [1:0]      head_op;
  logic            push, pop, want_j, redundant;

  // Ready looks only at the registered occupancy; a same-cycle pop does not free a slot.
  assign cmd.cmd_ready = !RESET && (count_reg < CW'(DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready && (cmd.cmd_op != OP_NOP);
  assign head_op       = fifo_mem[rd_ptr_reg];

  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    j_next       = 1'b0;
    k_next       = 1'b0;
    pop          = 1'b0;
    want_j       = 1'b0;
    redundant    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0) begin
          pop       = 1'b1;
          want_j    = (head_op == OP_SET) || ((head_op == OP_TGL) && !Q_fb);
          redundant = SKIP_REDUNDANT &&
                      (((head_op == OP_SET) && Q_fb) || ((head_op == OP_CLR) && !Q_fb));
          if (!redundant) begin
            j_next     = want_j;
            k_next     = !want_j;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (HAS_GAP) begin
          state_next   = ST_GAP;
          gap_cnt_next = 4'(GAP);
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg <= 4'd1) state_next = ST_IDLE;
        else                     gap_cnt_next = gap_cnt_reg - 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      gap_cnt_reg <= '0;
      j_reg       <= 1'b0;
      k_reg       <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      j_reg       <= j_next;
      k_reg       <= k_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it maps onto plain distributed memory.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= cmd.cmd_op;
  end

  assign J     = j_reg;
  assign K     = k_reg;
  assign count = count_reg;
  assign busy  = (state_reg != ST_IDLE) || (count_reg != '0);
endmodule
